// File: rtl/vend_pkg.sv
// Shared types and widths for the vending transaction controller.
// Optional auto-refund timeout is enabled by defining VEND_TIMEOUT_EN.
package vend_pkg;

    localparam int ITEM_W       = 10;
    localparam int COIN_W       = 8;
    localparam int PRICE_W      = 8;
    localparam int CREDIT_W_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_LOOKUP   = 3'd2,
        ST_CHECK    = 3'd3,
        ST_DISPENSE = 3'd4,
        ST_CHANGE   = 3'd5
    } state_t;

    // States in which new coins, selections and cancels are serviced.
    function automatic logic is_open(input state_t s);
        return (s == ST_IDLE) || (s == ST_COLLECT);
    endfunction

endpackage

// File: rtl/vend_txn_fsm_if.sv
// Bundle of request, configuration, handshake and status signals around vend_txn_fsm.
// master = upstream/output-stage side, slave = the transaction controller.
interface vend_txn_fsm_if
    import vend_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEF
);

    logic                currency_valid;
    logic [COIN_W-1:0]   currency_value;
    logic                item_valid;
    logic [ITEM_W-1:0]   item_select;
    logic                cancel_req;
    logic                cfg_we;
    logic [ITEM_W-1:0]   cfg_addr;
    logic [PRICE_W-1:0]  cfg_price;
    logic                dispense_valid;
    logic [ITEM_W-1:0]   dispense_item;
    logic                dispense_ready;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amount;
    logic                change_ready;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_reject;
    logic                err_invalid;
    logic                err_insufficient;
    logic                timeout_evt;

    modport master (
        output currency_valid, currency_value, item_valid, item_select, cancel_req,
               cfg_we, cfg_addr, cfg_price, dispense_ready, change_ready,
        input  dispense_valid, dispense_item, change_valid, change_amount,
               credit, busy, coin_reject, err_invalid, err_insufficient, timeout_evt
    );

    modport slave (
        input  currency_valid, currency_value, item_valid, item_select, cancel_req,
               cfg_we, cfg_addr, cfg_price, dispense_ready, change_ready,
        output dispense_valid, dispense_item, change_valid, change_amount,
               credit, busy, coin_reject, err_invalid, err_insufficient, timeout_evt
    );

endinterface

// File: rtl/vend_price_table.sv
// Programmable price table: one write port, one registered read port.
// A read and a write to the same entry in one cycle return the old price.
module vend_price_table
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS = 16
) (
    input  logic               clk_dst,
    input  logic               rstn,
    input  logic               wr_en,
    input  logic [ITEM_W-1:0]  wr_addr,
    input  logic [PRICE_W-1:0] wr_price,
    input  logic               rd_en,
    input  logic [ITEM_W-1:0]  rd_addr,
    output logic [PRICE_W-1:0] rd_price
);

    localparam int AW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    logic [PRICE_W-1:0] mem [NUM_ITEMS];
    logic               wr_hit;
    logic               rd_hit;

    assign wr_hit = wr_en && (wr_addr < ITEM_W'(NUM_ITEMS));
    assign rd_hit = rd_en && (rd_addr < ITEM_W'(NUM_ITEMS));

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the table is small flops, not a RAM macro, so it can and must reset: price 0 means unavailable.
            for (int i = 0; i < NUM_ITEMS; i++) begin
                mem[i] <= '0;
            end
            rd_price <= '0;
        end else begin
            if (wr_hit) begin
                mem[wr_addr[AW-1:0]] <= wr_price;
            end
            if (rd_hit) begin
                rd_price <= mem[rd_addr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/vend_txn_fsm.sv
// Vending transaction controller: credit accumulation, price check, dispense and change handshakes.
// Define VEND_TIMEOUT_EN to add the COLLECT-state auto-refund timer.
module vend_txn_fsm
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS      = 16,
    parameter int CREDIT_W       = CREDIT_W_DEF,
    parameter int CREDIT_MAX     = 2000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic           clk_dst,
    input logic           rstn,
    vend_txn_fsm_if.slave bus
);

    localparam int SUM_W = CREDIT_W + 1;

    if (TIMEOUT_CYCLES < 1 || CREDIT_MAX >= (1 << CREDIT_W) || NUM_ITEMS < 1) begin : g_param_check
        $error("vend_txn_fsm: inconsistent parameters");
    end

    state_t              state_q, state_d;
    state_t              rest_state;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ITEM_W-1:0]   item_q, item_d;
    logic [PRICE_W-1:0]  price;
    logic [CREDIT_W-1:0] price_ext;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_fits;
    logic                coin_accept;
    logic                item_in_range;
    logic                timeout_hit;
    logic                coin_reject_d, err_invalid_d, err_insuf_d, timeout_d;
    logic                coin_reject_q, err_invalid_q, err_insuf_q, timeout_q;

    assign coin_sum      = {1'b0, credit_q} + SUM_W'(bus.currency_value);
    assign coin_fits     = coin_sum <= SUM_W'(CREDIT_MAX);
    assign item_in_range = bus.item_select < ITEM_W'(NUM_ITEMS);
    assign price_ext     = CREDIT_W'(price);
    assign rest_state    = (credit_q != '0) ? ST_COLLECT : ST_IDLE;

    vend_price_table #(
        .NUM_ITEMS (NUM_ITEMS)
    ) u_price_table (
        .clk_dst  (clk_dst),
        .rstn     (rstn),
        .wr_en    (bus.cfg_we),
        .wr_addr  (bus.cfg_addr),
        .wr_price (bus.cfg_price),
        .rd_en    (state_q == ST_LOOKUP),
        .rd_addr  (item_q),
        .rd_price (price)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
        state_d       = state_q;
        credit_d      = credit_q;
        item_d        = item_q;
        coin_accept   = 1'b0;
        err_invalid_d = 1'b0;
        err_insuf_d   = 1'b0;
        timeout_d     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (bus.cancel_req && state_q == ST_COLLECT) begin
                    state_d = ST_CHANGE;
                end else if (bus.item_valid) begin
                    if (item_in_range) begin
                        item_d  = bus.item_select;
                        state_d = ST_LOOKUP;
                    end else begin
                        err_invalid_d = 1'b1;
                    end
                end else if (bus.currency_valid) begin
                    if (coin_fits) begin
                        coin_accept = 1'b1;
                        credit_d    = coin_sum[CREDIT_W-1:0];
                        state_d     = ST_COLLECT;
                    end
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = ST_CHANGE;
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                if (price == '0) begin
                    err_invalid_d = 1'b1;
                    state_d       = rest_state;
                end else if (credit_q < price_ext) begin
                    err_insuf_d = 1'b1;
                    state_d     = rest_state;
                end else begin
                    credit_d = credit_q - price_ext;
                    state_d  = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (bus.dispense_ready) begin
                    state_d = rest_state == ST_COLLECT ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (bus.change_ready) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Covers busy states, over-ceiling coins and coins losing to cancel/item.
        coin_reject_d = bus.currency_valid && !coin_accept;
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign timeout_hit = (state_q == ST_COLLECT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else if (state_q != ST_COLLECT || state_d != ST_COLLECT || coin_accept) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_dst or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            item_q        <= '0;
            coin_reject_q <= 1'b0;
            err_invalid_q <= 1'b0;
            err_insuf_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            credit_q      <= credit_d;
            item_q        <= item_d;
            coin_reject_q <= coin_reject_d;
            err_invalid_q <= err_invalid_d;
            err_insuf_q   <= err_insuf_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.dispense_valid   = (state_q == ST_DISPENSE);
    assign bus.dispense_item    = bus.dispense_valid ? item_q : '0;
    assign bus.change_valid     = (state_q == ST_CHANGE);
    assign bus.change_amount    = bus.change_valid ? credit_q : '0;
    assign bus.credit           = credit_q;
    assign bus.busy             = !is_open(state_q);
    assign bus.coin_reject      = coin_reject_q;
    assign bus.err_invalid      = err_invalid_q;
    assign bus.err_insufficient = err_insuf_q;
    assign bus.timeout_evt      = timeout_q;

endmodule

// File: tb/tb_vend_txn_fsm.sv
// Self-checking bench for vend_txn_fsm: directed scenarios plus randomized purchases,
// checked against a credit/price-list model. Timeout checks follow VEND_TIMEOUT_EN.
module tb_vend_txn_fsm;

    localparam int N_ITEMS = 16;
    localparam int CW      = 12;
    localparam int CMAX    = 2000;
    localparam int TO_CYC  = 100;

    logic clk_dst = 1'b0;
    logic rstn    = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    // Reference model: credit held, whether a session is open, and the price list.
    int   m_credit;
    bit   m_collect;
    int   m_price [N_ITEMS];

    vend_txn_fsm_if #(.CREDIT_W(CW)) bus ();

    vend_txn_fsm #(
        .NUM_ITEMS      (N_ITEMS),
        .CREDIT_W       (CW),
        .CREDIT_MAX     (CMAX),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk_dst (clk_dst),
        .rstn    (rstn),
        .bus     (bus)
    );

    always #5 clk_dst = ~clk_dst;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_dst);
    endtask

    task automatic model_reset();
        m_credit  = 0;
        m_collect = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) m_price[i] = 0;
    endtask

    task automatic program_price(input int addr, input int price);
        bus.cfg_we = 1'b1; bus.cfg_addr = 10'(addr); bus.cfg_price = 8'(price);
        tick();
        bus.cfg_we = 1'b0;
        if (addr < N_ITEMS) m_price[addr] = price;
    endtask

    task automatic coin(input int v);
        bit acc;
        acc = (m_credit + v <= CMAX);
        bus.currency_valid = 1'b1; bus.currency_value = 8'(v);
        tick();
        bus.currency_valid = 1'b0;
        if (acc) begin
            m_credit += v;
            m_collect = 1'b1;
        end
        check("coin_reject", 32'(bus.coin_reject), 32'(!acc));
        check("coin_credit", 32'(bus.credit), 32'(m_credit));
    endtask

    task automatic collect_change(input int c_wait);
        check("chg_valid", 32'(bus.change_valid), 32'd1);
        check("chg_amount", 32'(bus.change_amount), 32'(m_credit));
        for (int i = 0; i < c_wait; i++) begin
            tick();
            check("chg_hold_valid", 32'(bus.change_valid), 32'd1);
            check("chg_hold_amount", 32'(bus.change_amount), 32'(m_credit));
        end
        bus.change_ready = 1'b1;
        tick();
        bus.change_ready = 1'b0;
        m_credit  = 0;
        m_collect = 1'b0;
        check("chg_done_valid", 32'(bus.change_valid), 32'd0);
        check("chg_done_credit", 32'(bus.credit), 32'd0);
        check("chg_done_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic cancel_txn(input int c_wait, input int coin_v);
        bus.cancel_req = 1'b1;
        if (coin_v > 0) begin
            bus.currency_valid = 1'b1; bus.currency_value = 8'(coin_v);
        end
        tick();
        bus.cancel_req = 1'b0; bus.currency_valid = 1'b0;
        if (coin_v > 0) check("cancel_coin_reject", 32'(bus.coin_reject), 32'd1);
        if (m_collect) begin
            collect_change(c_wait);
        end else begin
            check("cancel_idle_busy", 32'(bus.busy), 32'd0);
            check("cancel_idle_chg", 32'(bus.change_valid), 32'd0);
        end
    endtask

    // Select an item; lk_price >= 0 rewrites that entry during the LOOKUP cycle.
    task automatic buy(input int item, input int d_wait, input int c_wait, input int lk_price);
        int price;
        bus.item_valid = 1'b1; bus.item_select = 10'(item);
        tick();
        bus.item_valid = 1'b0;
        if (item >= N_ITEMS) begin
            check("sel_range_err", 32'(bus.err_invalid), 32'd1);
            check("sel_range_busy", 32'(bus.busy), 32'd0);
            check("sel_range_credit", 32'(bus.credit), 32'(m_credit));
            return;
        end
        check("sel_lookup_busy", 32'(bus.busy), 32'd1);
        price = m_price[item];
        if (lk_price >= 0) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 10'(item); bus.cfg_price = 8'(lk_price);
        end
        tick();
        bus.cfg_we = 1'b0;
        if (lk_price >= 0) m_price[item] = lk_price;
        tick();
        check("sel_disp_valid", 32'(bus.dispense_valid), 32'(price != 0 && m_credit >= price));
        if (price == 0) begin
            check("sel_price0_err", 32'(bus.err_invalid), 32'd1);
            check("sel_price0_credit", 32'(bus.credit), 32'(m_credit));
            m_collect = (m_credit > 0);
        end else if (m_credit < price) begin
            check("sel_insuf_err", 32'(bus.err_insufficient), 32'd1);
            check("sel_insuf_credit", 32'(bus.credit), 32'(m_credit));
            check("sel_insuf_busy", 32'(bus.busy), 32'd0);
            m_collect = (m_credit > 0);
        end else begin
            m_credit -= price;
            check("disp_item", 32'(bus.dispense_item), 32'(item));
            check("disp_credit", 32'(bus.credit), 32'(m_credit));
            for (int i = 0; i < d_wait; i++) begin
                if (i == 0) begin
                    bus.currency_valid = 1'b1; bus.currency_value = 8'd10;
                end
                tick();
                bus.currency_valid = 1'b0;
                if (i == 0) check("disp_coin_reject", 32'(bus.coin_reject), 32'd1);
                check("disp_hold_valid", 32'(bus.dispense_valid), 32'd1);
                check("disp_hold_item", 32'(bus.dispense_item), 32'(item));
                check("disp_hold_credit", 32'(bus.credit), 32'(m_credit));
            end
            bus.dispense_ready = 1'b1;
            tick();
            bus.dispense_ready = 1'b0;
            if (m_credit > 0) begin
                collect_change(c_wait);
            end else begin
                m_collect = 1'b0;
                check("disp_done_busy", 32'(bus.busy), 32'd0);
                check("disp_done_chg", 32'(bus.change_valid), 32'd0);
            end
        end
    endtask

    initial begin
        int first_to;
        bus.currency_valid = 1'b0; bus.currency_value = '0;
        bus.item_valid     = 1'b0; bus.item_select    = '0;
        bus.cancel_req     = 1'b0;
        bus.cfg_we         = 1'b0; bus.cfg_addr       = '0; bus.cfg_price = '0;
        bus.dispense_ready = 1'b0; bus.change_ready   = 1'b0;
        model_reset();

        // Reset state
        tick(); tick();
        check("rst_disp_valid", 32'(bus.dispense_valid), 32'd0);
        check("rst_chg_valid", 32'(bus.change_valid), 32'd0);
        check("rst_credit", 32'(bus.credit), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pulses", 32'({bus.coin_reject, bus.err_invalid, bus.err_insufficient, bus.timeout_evt}), 32'd0);
        rstn = 1'b1;
        tick();

        // Basic purchase with change
        program_price(3, 25);
        coin(10); coin(10); coin(10);
        buy(3, 0, 0, -1);

        // Insufficient credit keeps the session open
        coin(10); coin(10);
        buy(3, 0, 0, -1);
        check("insuf_credit_kept", 32'(bus.credit), 32'd20);
        cancel_txn(0, 0);

        // Out-of-range index and unpriced item
        coin(10);
        buy(16, 0, 0, -1);
        buy(5, 0, 0, -1);
        cancel_txn(0, 0);

        // Credit ceiling, then a coin offered during DISPENSE
        for (int i = 0; i < 7; i++) coin(255);
        coin(210);
        coin(10);
        program_price(4, 5);
        buy(4, 2, 0, -1);

        // Cancel beats a same-cycle coin; change held for 5 cycles
        coin(10); coin(20);
        cancel_txn(5, 7);

        // Price rewritten during LOOKUP: the old price applies
        program_price(6, 40);
        coin(50);
        buy(6, 0, 0, 10);
        program_price(40, 99);

        // Idle in COLLECT
        coin(5);
        first_to = 0;
        for (int k = 1; k <= 150 && first_to == 0; k++) begin
            tick();
            if (bus.timeout_evt) first_to = k;
        end
`ifdef VEND_TIMEOUT_EN
        check("timeout_cycle", 32'(first_to), 32'(TO_CYC));
        collect_change(0);
`else
        check("timeout_absent", 32'(first_to), 32'd0);
        check("timeout_credit", 32'(bus.credit), 32'd5);
        cancel_txn(0, 0);
`endif

        // Reset during DISPENSE clears outputs immediately and wipes the table
        program_price(2, 5);
        coin(10);
        bus.item_valid = 1'b1; bus.item_select = 10'd2;
        tick();
        bus.item_valid = 1'b0;
        tick(); tick();
        check("pre_rst_disp", 32'(bus.dispense_valid), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_disp", 32'(bus.dispense_valid), 32'd0);
        check("mid_rst_item", 32'(bus.dispense_item), 32'd0);
        check("mid_rst_credit", 32'(bus.credit), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        tick(); tick();
        rstn = 1'b1;
        model_reset();
        tick();
        coin(10);
        buy(2, 0, 0, -1);
        cancel_txn(0, 0);

        // Randomized sessions
        for (int it = 0; it < 40; it++) begin
            int n;
            program_price($urandom_range(0, 19), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120));
            n = $urandom_range(0, 3);
            for (int c = 0; c < n; c++) coin(($urandom_range(0, 4) == 0) ? 255 : $urandom_range(1, 60));
            if ($urandom_range(0, 4) == 0) cancel_txn($urandom_range(0, 2), 0);
            else buy($urandom_range(0, 17), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        cancel_txn(1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
